// File: rtl/uart_rx_serial_pkg.sv
// Shared UART definitions: FSM state encodings and default frame constants,
// intended to be reused by the matching transmitter.
package uart_rx_serial_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    localparam int DEF_DATA_W      = 8;
    localparam int DEF_CLK_PER_BIT = 16;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous rxd pin; resets to the idle
// (high) line level so reset never looks like a start bit.
module uart_rx_sync (
    input  logic clk,
    input  logic ret,
    input  logic rxd,
    output logic line
);

    logic [1:0] sync_reg;

    always_ff @(posedge clk) begin
        if (!ret) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], rxd};
        end
    end

    assign line = sync_reg[1];

endmodule

// File: rtl/uart_rx_serial.sv
// Oversampling UART receiver with valid/ready output and framing, parity
// and overrun status. Define UART_RX_PARITY_EN to compile in the parity bit.
module uart_rx_serial
    import uart_rx_serial_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int CLK_PER_BIT = DEF_CLK_PER_BIT,
    parameter int STOP_BITS   = 1,
    parameter int PARITY_ODD  = 0
) (
    input  logic              clk,
    input  logic              ret,
    input  logic              rxd,
    input  logic              data_ready,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              frame_err,
    output logic              parity_err,
    output logic              overrun,
    output logic              busy
);

    localparam int BAUD_W = $clog2(CLK_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_W + 1);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLK_PER_BIT / 2 - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
    localparam logic              PAR_SENSE = (PARITY_ODD != 0);

`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] ST_AFTER_DATA = ST_PARITY;
`else
    localparam logic [2:0] ST_AFTER_DATA = ST_STOP;
`endif

    logic              line;
    logic [2:0]        state_reg;
    logic [BAUD_W-1:0] baud_cnt_reg;
    logic [BIT_W-1:0]  bit_cnt_reg;
    logic [DATA_W-1:0] shift_reg;
    logic              frame_pend_reg;
    logic              parity_pend_reg;
    logic [DATA_W-1:0] data_out_reg;
    logic              data_valid_reg;
    logic              frame_err_reg;
    logic              parity_err_reg;
    logic              overrun_reg;
    logic              mid_bit;

    uart_rx_sync u_sync (
        .clk  (clk),
        .ret  (ret),
        .rxd  (rxd),
        .line (line)
    );

    assign mid_bit = (baud_cnt_reg == BAUD_LAST);

    always_ff @(posedge clk) begin
        if (!ret) begin
            state_reg       <= ST_IDLE;
            baud_cnt_reg    <= '0;
            bit_cnt_reg     <= '0;
            shift_reg       <= '0;
            frame_pend_reg  <= 1'b0;
            parity_pend_reg <= 1'b0;
            data_out_reg    <= '0;
            data_valid_reg  <= 1'b0;
            frame_err_reg   <= 1'b0;
            parity_err_reg  <= 1'b0;
            overrun_reg     <= 1'b0;
        end else begin
            overrun_reg <= 1'b0;
            if (data_valid_reg && data_ready) begin
                data_valid_reg <= 1'b0;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (!line) begin
                        state_reg       <= ST_START;
                        baud_cnt_reg    <= '0;
                        frame_pend_reg  <= 1'b0;
                        parity_pend_reg <= 1'b0;
                    end
                end

                ST_START: begin
                    // Half a bit in: still low means a real start bit.
                    if (baud_cnt_reg == HALF_LAST) begin
                        baud_cnt_reg <= '0;
                        bit_cnt_reg  <= '0;
                        state_reg    <= line ? ST_IDLE : ST_DATA;
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + BAUD_W'(1);
                    end
                end

                ST_DATA: begin
                    if (mid_bit) begin
                        baud_cnt_reg <= '0;
                        shift_reg    <= {line, shift_reg[DATA_W-1:1]};
                        if (bit_cnt_reg == DATA_LAST) begin
                            bit_cnt_reg <= '0;
                            state_reg   <= ST_AFTER_DATA;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + BIT_W'(1);
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + BAUD_W'(1);
                    end
                end

`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (mid_bit) begin
                        baud_cnt_reg    <= '0;
                        parity_pend_reg <= ((^shift_reg) ^ line) != PAR_SENSE;
                        state_reg       <= ST_STOP;
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + BAUD_W'(1);
                    end
                end
`endif

                ST_STOP: begin
                    if (mid_bit) begin
                        baud_cnt_reg <= '0;
                        if (bit_cnt_reg == STOP_LAST) begin
                            // Load on the last stop sample so back-to-back frames are caught.
                            bit_cnt_reg    <= '0;
                            state_reg      <= ST_IDLE;
                            data_out_reg   <= shift_reg;
                            frame_err_reg  <= frame_pend_reg | ~line;
                            parity_err_reg <= parity_pend_reg;
                            data_valid_reg <= 1'b1;
                            overrun_reg    <= data_valid_reg && !data_ready;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + BIT_W'(1);
                            if (!line) begin
                                frame_pend_reg <= 1'b1;
                            end
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + BAUD_W'(1);
                    end
                end

                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign data_out   = data_out_reg;
    assign data_valid = data_valid_reg;
    assign frame_err  = frame_err_reg;
    assign overrun    = overrun_reg;
    assign busy       = (state_reg != ST_IDLE);

`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_reg;
`else
    // Without a parity bit the sense setting has no effect.
    assign parity_err = parity_err_reg & PAR_SENSE & 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_serial.sv
// Directed bench for uart_rx_serial: frames are driven bit by bit, expected
// words go to a scoreboard queue and are checked as the receiver presents them.
module tb_uart_rx_serial;

    localparam int   CPB     = 16;
    localparam logic PAR_ODD = 1'b0;

    typedef struct {
        logic [7:0] data;
        logic       ferr;
        logic       perr;
    } exp_t;

    logic       clk = 1'b0;
    logic       ret = 1'b0;
    logic       rxd = 1'b1;
    logic       data_ready = 1'b1;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       parity_err;
    logic       overrun;
    logic       busy;

    int   errors = 0;
    int   checks = 0;
    int   overrun_cnt = 0;
    int   valid_cnt = 0;
    exp_t exp_q[$];

    uart_rx_serial #(
        .DATA_W      (8),
        .CLK_PER_BIT (CPB),
        .STOP_BITS   (1),
        .PARITY_ODD  (0)
    ) dut (
        .clk        (clk),
        .ret        (ret),
        .rxd        (rxd),
        .data_ready (data_ready),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        rxd = b;
        repeat (CPB) @(negedge clk);
    endtask

    function automatic logic good_par(input logic [7:0] d);
        return (^d) ^ PAR_ODD;
    endfunction

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        exp_t e;
        e.data = d;
        e.ferr = ~stop;
`ifdef UART_RX_PARITY_EN
        e.perr = ((^d) ^ par) != PAR_ODD;
`else
        e.perr = 1'b0;
`endif
        exp_q.push_back(e);
        $display("send data=%02h par=%0b stop=%0b", d, par, stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(par);
`endif
        send_bit(stop);
        rxd = 1'b1;
    endtask

    // Output monitor: a new word is on data_out when valid rises, follows an
    // accept while staying high, or overwrites an unaccepted word.
    always @(posedge clk) begin
        logic pre_v;
        logic pre_r;
        exp_t e;
        pre_v = data_valid;
        pre_r = data_ready;
        #1;
        if (overrun === 1'b1) overrun_cnt++;
        if (data_valid === 1'b1) valid_cnt++;
        if (data_valid === 1'b1 && (!pre_v || pre_r || overrun === 1'b1)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", {24'h0, data_out}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                $display("recv data=%02h ferr=%0b perr=%0b ovr=%0b", data_out, frame_err, parity_err, overrun);
                check("word_data", {24'h0, data_out}, {24'h0, e.data});
                check("word_frame_err", {31'h0, frame_err}, {31'h0, e.ferr});
                check("word_parity_err", {31'h0, parity_err}, {31'h0, e.perr});
            end
        end
    end

    initial begin
        int v0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_data_out", {24'h0, data_out}, 32'h0);
        check("rst_data_valid", {31'h0, data_valid}, 32'h0);
        check("rst_frame_err", {31'h0, frame_err}, 32'h0);
        check("rst_parity_err", {31'h0, parity_err}, 32'h0);
        check("rst_overrun", {31'h0, overrun}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        ret = 1'b1;
        idle(10);

        // 1: clean frame, consumer ready
        v0 = valid_cnt;
        send_frame(8'hA5, good_par(8'hA5), 1'b1);
        idle(20);
        check("t1_drained", exp_q.size(), 32'h0);
        check("t1_valid_cycles", valid_cnt - v0, 32'd1);
        check("t1_valid_low", {31'h0, data_valid}, 32'h0);

        // 2: 8-cycle glitch is rejected
        rxd = 1'b0;
        repeat (8) @(negedge clk);
        rxd = 1'b1;
        check("t2_busy_in_start", {31'h0, busy}, 32'h1);
        repeat (6) @(negedge clk);
        check("t2_busy_dropped", {31'h0, busy}, 32'h0);
        check("t2_no_valid", {31'h0, data_valid}, 32'h0);
        idle(10);

        // 3: bad stop bit, then a clean frame clears the flag
        send_frame(8'h3C, good_par(8'h3C), 1'b0);
        idle(2);
        check("t3_frame_err", {31'h0, frame_err}, 32'h1);
        idle(30);
        send_frame(8'h01, good_par(8'h01), 1'b1);
        idle(20);
        check("t3_frame_err_clear", {31'h0, frame_err}, 32'h0);

`ifdef UART_RX_PARITY_EN
        // 4: parity mismatch and match
        send_frame(8'h07, 1'b0, 1'b1);
        idle(2);
        check("t4_parity_bad", {31'h0, parity_err}, 32'h1);
        idle(20);
        send_frame(8'h07, 1'b1, 1'b1);
        idle(2);
        check("t4_parity_good", {31'h0, parity_err}, 32'h0);
        idle(20);
`endif

        // 5: overrun on back-to-back frames with consumer stalled
        data_ready = 1'b0;
        overrun_cnt = 0;
        send_frame(8'h11, good_par(8'h11), 1'b1);
        send_frame(8'h22, good_par(8'h22), 1'b1);
        idle(4);
        check("t5_overrun_cycles", overrun_cnt, 32'd1);
        check("t5_data_out", {24'h0, data_out}, 32'h22);
        check("t5_valid_held", {31'h0, data_valid}, 32'h1);
        data_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("t5_valid_cleared", {31'h0, data_valid}, 32'h0);
        idle(10);

        // 6: reset during data bit 4 discards the frame
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(i[0]);
        repeat (CPB / 2) @(negedge clk);
        check("t6_busy_before", {31'h0, busy}, 32'h1);
        ret = 1'b0;
        @(negedge clk);
        check("t6_data_out", {24'h0, data_out}, 32'h0);
        check("t6_data_valid", {31'h0, data_valid}, 32'h0);
        check("t6_frame_err", {31'h0, frame_err}, 32'h0);
        check("t6_parity_err", {31'h0, parity_err}, 32'h0);
        check("t6_overrun", {31'h0, overrun}, 32'h0);
        check("t6_busy", {31'h0, busy}, 32'h0);
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        ret = 1'b1;
        idle(20);
        send_frame(8'h5A, good_par(8'h5A), 1'b1);
        idle(20);
        check("t6_data_after", {24'h0, data_out}, 32'h5A);

        check("final_queue_empty", exp_q.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
